// File: rtl/cpu_data_ram.sv
// rtl/cpu_data_ram.sv - parametrised CPU data RAM: power-up init, registered reads, range check
// Optional conflict monitor enabled by CPU_DATA_RAM_CONFLICT_CHK_EN
module cpu_data_ram #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int RD_LAT    = 1,
   parameter int INIT_MULT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address_to_ram,
   input  logic              read_enable_to_ram,
   input  logic              write_enable_to_ram,
   inout  wire  [DATA_W-1:0] data_ram,
   output logic              rd_valid,
   output logic              ready,
   output logic              init_done,
   output logic              addr_err
`ifdef CPU_DATA_RAM_CONFLICT_CHK_EN
   ,
   output logic              conflict,
   output logic [7:0]        conflict_cnt
`endif
);
   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              pipe_v [RD_LAT];
   logic [DATA_W-1:0] pipe_d [RD_LAT];
   logic              pipe_e [RD_LAT];
   logic              wr_err_q;
   logic              in_range;
   logic              wr_acc;
   logic              rd_acc;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] init_val;

   // ready doubles as the RUN qualifier: requests outside RUN are ignored entirely
   always_comb begin
      in_range = {1'b0, address_to_ram} < (ADDR_W+1)'(DEPTH);
      wr_acc   = ready && write_enable_to_ram;
      rd_acc   = ready && read_enable_to_ram && !write_enable_to_ram;
      rd_word  = in_range ? mem[address_to_ram] : '0;
      init_val = DATA_W'(INIT_MULT) * DATA_W'(ptr);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == S_INIT) begin
            mem[ptr] <= init_val;
         end else if (wr_acc && in_range) begin
            mem[address_to_ram] <= data_ram;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_INIT;
         ptr       <= '0;
         ready     <= 1'b0;
         init_done <= 1'b0;
         wr_err_q  <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= '0;
            pipe_e[i] <= 1'b0;
         end
      end else begin
         wr_err_q  <= wr_acc && !in_range;
         pipe_v[0] <= rd_acc;
         pipe_d[0] <= rd_word;
         pipe_e[0] <= rd_acc && !in_range;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
            pipe_e[i] <= pipe_e[i-1];
         end
         if (state == S_INIT) begin
            if (ptr == ADDR_W'(DEPTH-1)) begin
               state     <= S_RUN;
               ready     <= 1'b1;
               init_done <= 1'b1;
            end else begin
               ptr <= ptr + 1'b1;
            end
         end
      end
   end

   assign rd_valid = pipe_v[RD_LAT-1];
   assign addr_err = pipe_e[RD_LAT-1] | wr_err_q;

   // A write request takes the bus back immediately, even if that loses a read result
   assign data_ram = (rd_valid && !write_enable_to_ram) ? pipe_d[RD_LAT-1] : 'z;

`ifdef CPU_DATA_RAM_CONFLICT_CHK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict     <= 1'b0;
         conflict_cnt <= 8'd0;
      end else if (ready && write_enable_to_ram && (read_enable_to_ram || rd_valid)) begin
         conflict <= 1'b1;
         if (conflict_cnt != 8'hFF) begin
            conflict_cnt <= conflict_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cpu_data_ram.sv
// tb/tb_cpu_data_ram.sv - three cpu_data_ram configurations driven in lockstep against a model
module tb_cpu_data_ram;
   localparam int DW = 16;
   localparam int AW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset  = 1'b1;
   logic [AW-1:0] addr_r = '0;
   logic          re_r   = 1'b0;
   logic          we_r   = 1'b0;
   logic [DW-1:0] wd_r   = '0;
   logic          chk_on = 1'b0;
   logic          zen    = 1'b0;

   wire [DW-1:0] bus0, bus1, bus2, z_ref;
   wire [2:0]    rdv, rdy, idn, aer;

   assign bus0  = we_r ? wd_r : 'z;
   assign bus1  = we_r ? wd_r : 'z;
   assign bus2  = we_r ? wd_r : 'z;
   assign z_ref = zen ? '0 : 'z;

`ifdef CPU_DATA_RAM_CONFLICT_CHK_EN
   wire [2:0] cf;
   wire [7:0] cc0, cc1, cc2;
`endif

   cpu_data_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .RD_LAT(1), .INIT_MULT(2)) u_lat1 (
      .clk(clk), .reset(reset), .address_to_ram(addr_r), .read_enable_to_ram(re_r),
      .write_enable_to_ram(we_r), .data_ram(bus0), .rd_valid(rdv[0]), .ready(rdy[0]),
      .init_done(idn[0]), .addr_err(aer[0])
`ifdef CPU_DATA_RAM_CONFLICT_CHK_EN
      , .conflict(cf[0]), .conflict_cnt(cc0)
`endif
   );

   cpu_data_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .RD_LAT(3), .INIT_MULT(2)) u_lat3 (
      .clk(clk), .reset(reset), .address_to_ram(addr_r), .read_enable_to_ram(re_r),
      .write_enable_to_ram(we_r), .data_ram(bus1), .rd_valid(rdv[1]), .ready(rdy[1]),
      .init_done(idn[1]), .addr_err(aer[1])
`ifdef CPU_DATA_RAM_CONFLICT_CHK_EN
      , .conflict(cf[1]), .conflict_cnt(cc1)
`endif
   );

   cpu_data_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(48), .RD_LAT(1), .INIT_MULT(2)) u_d48 (
      .clk(clk), .reset(reset), .address_to_ram(addr_r), .read_enable_to_ram(re_r),
      .write_enable_to_ram(we_r), .data_ram(bus2), .rd_valid(rdv[2]), .ready(rdy[2]),
      .init_done(idn[2]), .addr_err(aer[2])
`ifdef CPU_DATA_RAM_CONFLICT_CHK_EN
      , .conflict(cf[2]), .conflict_cnt(cc2)
`endif
   );

   function automatic int dep(input int k);
      return (k == 2) ? 48 : 64;
   endfunction

   function automatic int lat(input int k);
      return (k == 1) ? 3 : 1;
   endfunction

   // Model: expected rd_valid/data/addr_err per output cycle, in a ring of 16 cycle slots
   int            cyc = 0;
   int            since [3];
   bit            ev [3][16];
   bit            ee [3][16];
   logic [DW-1:0] ed [3][16];
   logic [DW-1:0] mem_m [3][64];
   bit            conf_m [3];
   int            cnt_m [3];

   initial begin
      int  ps, ds;
      bit  was_v, acc, oor;
      for (int k = 0; k < 3; k++) begin
         since[k] = 0; conf_m[k] = 0; cnt_m[k] = 0;
         for (int s = 0; s < 16; s++) begin ev[k][s] = 0; ee[k][s] = 0; ed[k][s] = '0; end
      end
      forever begin
         @(posedge clk);
         cyc++;
         ps = (cyc - 1) % 16;
         for (int k = 0; k < 3; k++) begin
            was_v = ev[k][ps];
            ev[k][ps] = 0;
            ee[k][ps] = 0;
            if (reset) begin
               since[k] = 0;
               conf_m[k] = 0;
               cnt_m[k] = 0;
               for (int s = 0; s < 16; s++) begin ev[k][s] = 0; ee[k][s] = 0; end
               for (int i = 0; i < 64; i++) mem_m[k][i] = DW'(2 * i);
            end else begin
               acc = since[k] >= dep(k);
               if (since[k] < 10000) since[k]++;
               oor = int'(addr_r) >= dep(k);
               if (acc) begin
                  if (we_r) begin
                     if (oor) ee[k][cyc % 16] = 1;
                     else mem_m[k][addr_r] = wd_r;
                  end else if (re_r) begin
                     ds = (cyc + lat(k) - 1) % 16;
                     ev[k][ds] = 1;
                     ed[k][ds] = oor ? '0 : mem_m[k][addr_r];
                     if (oor) ee[k][ds] = 1;
                  end
                  if (we_r && (re_r || was_v)) begin
                     conf_m[k] = 1;
                     if (cnt_m[k] < 255) cnt_m[k]++;
                  end
               end
            end
         end
      end
   end

   int            n_vec = 0;
   int            n_bad = 0;
   logic [3:0]    pin_m = '0;
   logic [DW-1:0] pin_e [4];
   int            pin_c = 0;

   task automatic check(input string name, input int k, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] cycle %0d: got %h, want %h", name, k, cyc, act, exp);
      end
   endtask

   initial begin
      int            s;
      logic [DW-1:0] bus, exp_bus;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            s = cyc % 16;
            for (int k = 0; k < 3; k++) begin
               bus = (k == 0) ? bus0 : (k == 1) ? bus1 : bus2;
               if (we_r) exp_bus = wd_r;
               else if (ev[k][s]) exp_bus = ed[k][s];
               else exp_bus = z_ref;
               check("rd_valid", k, DW'(rdv[k]), DW'(ev[k][s]));
               check("addr_err", k, DW'(aer[k]), DW'(ee[k][s]));
               check("ready", k, DW'(rdy[k]), DW'(since[k] >= dep(k)));
               check("init_done", k, DW'(idn[k]), DW'(since[k] >= dep(k)));
               check("data_ram", k, bus, exp_bus);
`ifdef CPU_DATA_RAM_CONFLICT_CHK_EN
               check("conflict", k, DW'(cf[k]), DW'(conf_m[k]));
               check("conflict_cnt", k, DW'((k == 0) ? cc0 : (k == 1) ? cc1 : cc2), DW'(cnt_m[k]));
`endif
            end
         end
         if (pin_m[0]) check("pin_bus", 0, bus0, pin_e[0]);
         if (pin_m[1]) check("pin_bus", 1, bus1, pin_e[1]);
         if (pin_m[2]) check("pin_bus", 2, bus2, pin_e[2]);
         if (pin_m[3]) check("pin_init_cycles", 0, DW'(pin_c), pin_e[3]);
      end
   end

   task automatic pin(input logic [3:0] m, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                      input logic [DW-1:0] e2, input logic [DW-1:0] e3);
      pin_m = m;
      pin_e[0] = e0; pin_e[1] = e1; pin_e[2] = e2; pin_e[3] = e3;
      @(negedge clk);
      #1;
      pin_m = '0;
   endtask

   task automatic req(input logic re, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
      re_r = re; we_r = we; addr_r = a; wd_r = d;
      @(posedge clk);
      #1;
      re_r = 1'b0; we_r = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rd_pin(input logic [AW-1:0] a, input logic [DW-1:0] e0,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      req(1'b1, 1'b0, a, '0);
      pin(4'b0101, e0, '0, e2, '0);
      idle(2);
      pin(4'b0010, '0, e1, '0, '0);
   endtask

   task automatic count_init();
      int cnt;
      cnt = 0;
      while (!rdy[0] && cnt < 200) begin
         @(negedge clk);
         if (!rdy[0]) cnt++;
      end
      pin_c = cnt;
      pin(4'b1000, '0, '0, '0, 16'd64);
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      #1;
      chk_on = 1'b1;
      idle(6);
      reset = 1'b0;
      count_init();

      rd_pin(6'd10, 16'h0014, 16'h0014, 16'h0014);
      req(1'b0, 1'b1, 6'd16, 16'h0000);
      rd_pin(6'd16, 16'h0000, 16'h0000, 16'h0000);
      rd_pin(6'd17, 16'h0022, 16'h0022, 16'h0022);
      rd_pin(6'd63, 16'h007E, 16'h007E, 16'h0000);
      rd_pin(6'd47, 16'h005E, 16'h005E, 16'h005E);

      req(1'b1, 1'b0, 6'd1, '0);
      req(1'b1, 1'b0, 6'd2, '0);
      req(1'b1, 1'b0, 6'd3, '0);
      pin(4'b0111, 16'h0006, 16'h0002, 16'h0006, '0);
      idle(1);
      pin(4'b0010, '0, 16'h0004, '0, '0);
      idle(1);
      pin(4'b0010, '0, 16'h0006, '0, '0);
      idle(1);

      req(1'b1, 1'b1, 6'd5, 16'hBEEF);
      idle(3);
      rd_pin(6'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF);

      req(1'b1, 1'b0, 6'd7, '0);
      req(1'b0, 1'b1, 6'd8, 16'h1111);
      idle(3);
      rd_pin(6'd8, 16'h1111, 16'h1111, 16'h1111);

      rd_pin(6'd50, 16'h0064, 16'h0064, 16'h0000);
      req(1'b0, 1'b1, 6'd50, 16'h1234);
      idle(1);
      rd_pin(6'd2, 16'h0004, 16'h0004, 16'h0004);
      rd_pin(6'd50, 16'h1234, 16'h1234, 16'h0000);

      req(1'b1, 1'b0, 6'd3, '0);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(30);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      count_init();

      rd_pin(6'd40, 16'h0050, 16'h0050, 16'h0050);
      rd_pin(6'd5, 16'h000A, 16'h000A, 16'h000A);
      rd_pin(6'd16, 16'h0020, 16'h0020, 16'h0020);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
